// File: rtl/cache_ram_pkg.sv
// Shared definitions for the cache RAM request interface: request type codes,
// bus widths, line geometry and the responder FSM state encoding.
package cache_ram_pkg;

    localparam int RV32_ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH       = 32;
    localparam int CACHE_BANK_WIDTH = 128;
    localparam int LINE_BEATS       = 4;

    localparam logic [2:0] RAM_TYPE_BYTE = 3'b000;
    localparam logic [2:0] RAM_TYPE_HALF = 3'b001;
    localparam logic [2:0] RAM_TYPE_WORD = 3'b010;
    localparam logic [2:0] RAM_TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR       = 2'd1,
        RD_WAIT  = 2'd2,
        RD_BURST = 2'd3
    } ram_state_e;

    function automatic logic ram_type_legal(input logic [2:0] t);
        logic legal;
        case (t)
            RAM_TYPE_BYTE, RAM_TYPE_HALF, RAM_TYPE_WORD, RAM_TYPE_LINE: legal = 1'b1;
            default:                                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/cache_ram_array.sv
// Single-port backing store: DEPTH_WORDS x 32 with per-byte write enables and a
// registered read port. Contents are never reset; only the read register is.
module cache_ram_array
    import cache_ram_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic                           rd_en_i,
    input  logic [3:0]                     wr_be_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    output logic [DATA_WIDTH-1:0]          rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Byte-lane writes into the storage array
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
            end
        end
    end

    // Read register; holds its value between reads so beat data stays stable
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= 32'd0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cache_ram_responder.sv
// Memory-side responder for the cache RAM interface: serialises refill reads and
// writebacks onto one single-port array and streams read data back as beats.
module cache_ram_responder
    import cache_ram_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int RD_LATENCY  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ram_rd_req_i,
    input  logic [2:0]                  ram_rd_type_i,
    input  logic [RV32_ADDR_WIDTH-1:0]  ram_rd_addr_i,
    output logic                        ram_rd_rdy_o,
    output logic [DATA_WIDTH-1:0]       ram_rd_data_o,
    output logic                        ram_rd_valid_o,
    output logic [1:0]                  ram_rd_last_o,
    input  logic                        ram_wr_req_i,
    input  logic [2:0]                  ram_wr_type_i,
    input  logic [3:0]                  ram_wr_en_i,
    input  logic [RV32_ADDR_WIDTH-1:0]  ram_wr_addr_i,
    input  logic [CACHE_BANK_WIDTH-1:0] ram_wr_data_i,
    output logic                        ram_wr_rdy_o,
    output logic                        err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    ram_state_e                  state_q, state_d;
    logic [AW-1:0]               widx_q, widx_d;
    logic [2:0]                  type_q, type_d;
    logic [3:0]                  be_q, be_d;
    logic [CACHE_BANK_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]                  beat_q, beat_d;
    logic [3:0]                  wait_q, wait_d;
    logic                        rd_rdy_q, rd_rdy_d;
    logic                        wr_rdy_q, wr_rdy_d;
    logic                        valid_q, valid_d;
    logic                        last_q, last_d;
    logic                        err_q, err_d;

    logic [AW-1:0]               line_base_s;
    logic [1:0]                  final_beat_s;
    logic [AW-1:0]               arr_addr_s;
    logic                        arr_rd_en_s;
    logic [3:0]                  arr_be_s;
    logic [DATA_WIDTH-1:0]       arr_wdata_s;
    logic [DATA_WIDTH-1:0]       arr_rdata_s;
    logic                        unused_s;

    // Next-state, datapath latch and array-port control
    always_comb begin
        state_d      = state_q;
        widx_d       = widx_q;
        type_d       = type_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        beat_d       = beat_q;
        wait_d       = wait_q;
        err_d        = 1'b0;
        line_base_s  = widx_q & ~AW'(32'd3);
        final_beat_s = (type_q == RAM_TYPE_LINE) ? 2'd3 : 2'd0;
        arr_addr_s   = widx_q;
        arr_rd_en_s  = 1'b0;
        arr_be_s     = 4'b0000;
        arr_wdata_s  = wdata_q[31:0];

        case (state_q)
            IDLE: begin
                // Write wins so a dirty writeback lands before the refill of its line
                if (ram_wr_req_i && wr_rdy_q) begin
                    widx_d  = ram_wr_addr_i[AW+1:2];
                    type_d  = ram_wr_type_i;
                    be_d    = ram_wr_en_i;
                    wdata_d = ram_wr_data_i;
                    beat_d  = 2'd0;
                    err_d   = ~ram_type_legal(ram_wr_type_i);
                    state_d = WR;
                end else if (ram_rd_req_i && rd_rdy_q) begin
                    widx_d  = ram_rd_addr_i[AW+1:2];
                    type_d  = ram_rd_type_i;
                    beat_d  = 2'd0;
                    wait_d  = 4'd0;
                    err_d   = ~ram_type_legal(ram_rd_type_i);
                    state_d = RD_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WR: begin
                if (type_q == RAM_TYPE_LINE) begin
                    arr_addr_s  = line_base_s | AW'(beat_q);
                    arr_be_s    = 4'b1111;
                    arr_wdata_s = wdata_q[32*beat_q +: 32];
                    if (beat_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end else if (ram_type_legal(type_q)) begin
                    arr_be_s = be_q;
                    state_d  = IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (wait_q == 4'(RD_LATENCY)) begin
                    arr_rd_en_s = 1'b1;
                    arr_addr_s  = (type_q == RAM_TYPE_LINE) ? line_base_s : widx_q;
                    state_d     = RD_BURST;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            RD_BURST: begin
                // Each cycle shows one beat and prefetches the next, so bursts are gapless
                if (beat_q == final_beat_s) begin
                    state_d = IDLE;
                end else begin
                    beat_d      = beat_q + 2'd1;
                    arr_rd_en_s = 1'b1;
                    arr_addr_s  = line_base_s | AW'(beat_d);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_rdy_d = (state_d == IDLE);
        wr_rdy_d = (state_d == IDLE);
        valid_d  = (state_d == RD_BURST);
        last_d   = (state_d == RD_BURST) && (beat_d == final_beat_s);
    end

    // Control state and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= 2'd0;
            wait_q   <= 4'd0;
            rd_rdy_q <= 1'b0;
            wr_rdy_q <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
            rd_rdy_q <= rd_rdy_d;
            wr_rdy_q <= wr_rdy_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    // Request payload captured at acceptance
    always_ff @(posedge clk) begin
        widx_q  <= widx_d;
        type_q  <= type_d;
        be_q    <= be_d;
        wdata_q <= wdata_d;
    end

    cache_ram_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .addr_i    (arr_addr_s),
        .rd_en_i   (arr_rd_en_s),
        .wr_be_i   (arr_be_s),
        .wr_data_i (arr_wdata_s),
        .rd_data_o (arr_rdata_s)
    );

    // Address bits outside the word index wrap away by design
    assign unused_s = ^{ram_rd_addr_i[RV32_ADDR_WIDTH-1:AW+2], ram_rd_addr_i[1:0],
                        ram_wr_addr_i[RV32_ADDR_WIDTH-1:AW+2], ram_wr_addr_i[1:0]};

    assign ram_rd_rdy_o   = rd_rdy_q;
    assign ram_wr_rdy_o   = wr_rdy_q;
    assign ram_rd_valid_o = valid_q;
    assign ram_rd_last_o  = {1'b0, last_q};
    assign ram_rd_data_o  = arr_rdata_s;
    assign err_o          = err_q;

endmodule
